ub_arbiter: RTL and testbench



---
 rtl/ub_arbiter_pkg.sv | 14 +
 rtl/ub_arbiter_rr_select.sv | 29 ++
 rtl/ub_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ub_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ub_arbiter_pkg.sv
// rtl/ub_arbiter_pkg.sv - shared arbiter state type and unified-buffer requester indices
package ub_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int REQ_DMA  = 0;
    localparam int REQ_FEED = 1;
    localparam int REQ_WB   = 2;

endpackage

// File: rtl/ub_arbiter_rr_select.sv
// rtl/ub_arbiter_rr_select.sv - combinational round-robin winner pick, searching from last_owner+1 with wrap
module rr_select #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest requester overwrites.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ub_arbiter.sv
// rtl/ub_arbiter.sv - round-robin burst arbiter granting unified-buffer access to DMA, feeder and writeback
module ub_arbiter
    import ub_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          ASYNC_RST,
    input  logic                          SYNC_RST,
    input  logic                          EN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*BURST_WIDTH-1:0] req_len,
    input  logic [NUM_REQ-1:0]            beat_valid,
    input  logic [NUM_REQ-1:0]            beat_wren,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] beat_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] beat_wrdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          busy,
    output logic                          UB_en,
    output logic                          UB_wren,
    output logic [ADDR_WIDTH-1:0]         UB_wraddr,
    output logic [DATA_WIDTH-1:0]         UB_wrdata,
    output logic [ADDR_WIDTH-1:0]         UB_rdaddr,
    input  logic [DATA_WIDTH-1:0]         UB_rddata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = BURST_WIDTH + 1;

    arb_state_e             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last_owner;
    logic [IDX_W-1:0]       win_idx;
    logic [NUM_REQ-1:0]     win_onehot;
    logic                   win_valid;
    logic [BURST_WIDTH-1:0] win_len;
    logic [CNT_W-1:0]       beat_cnt;
    logic [CNT_W-1:0]       beat_target;
    logic [NUM_REQ-1:0]     rd_pend;
    logic                   owner_req;
    logic                   owner_valid;
    logic                   owner_wren;
    logic [ADDR_WIDTH-1:0]  owner_addr;
    logic [DATA_WIDTH-1:0]  owner_wrdata;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (req),
        .last_owner (last_owner),
        .winner     (win_onehot),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) win_idx = IDX_W'(i);
        end
    end

    assign win_len      = req_len[win_idx*BURST_WIDTH +: BURST_WIDTH];
    assign owner_req    = req[owner];
    assign owner_valid  = beat_valid[owner];
    assign owner_wren   = beat_wren[owner];
    assign owner_addr   = beat_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
    assign owner_wrdata = beat_wrdata[owner*DATA_WIDTH +: DATA_WIDTH];
    assign rd_data      = UB_rddata;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
            beat_target <= '0;
            rd_pend     <= '0;
            gnt         <= '0;
            rd_valid    <= '0;
            busy        <= 1'b0;
            UB_en       <= 1'b0;
            UB_wren     <= 1'b0;
            UB_wraddr   <= '0;
            UB_wrdata   <= '0;
            UB_rdaddr   <= '0;
        end else if (EN) begin
            if (SYNC_RST) begin
                state       <= IDLE;
                owner       <= '0;
                last_owner  <= IDX_W'(NUM_REQ - 1);
                beat_cnt    <= '0;
                beat_target <= '0;
                rd_pend     <= '0;
                gnt         <= '0;
                rd_valid    <= '0;
                busy        <= 1'b0;
                UB_en       <= 1'b0;
                UB_wren     <= 1'b0;
                UB_wraddr   <= '0;
                UB_wrdata   <= '0;
                UB_rdaddr   <= '0;
            end else begin
                // Read data lands one cycle after UB_rdaddr; rd_valid tracks it one stage later.
                rd_valid <= rd_pend;
                rd_pend  <= '0;
                case (state)
                    IDLE: begin
                        UB_en   <= 1'b0;
                        UB_wren <= 1'b0;
                        if (win_valid) begin
                            owner       <= win_idx;
                            last_owner  <= win_idx;
                            gnt         <= win_onehot;
                            busy        <= 1'b1;
                            beat_cnt    <= '0;
                            beat_target <= (win_len == '0) ? CNT_W'(1) : CNT_W'(win_len);
                            state       <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (!owner_req) begin
                            gnt     <= '0;
                            busy    <= 1'b0;
                            UB_en   <= 1'b0;
                            UB_wren <= 1'b0;
                            state   <= RELEASE;
                        end else if (owner_valid) begin
                            UB_en   <= 1'b1;
                            UB_wren <= owner_wren;
                            if (owner_wren) begin
                                UB_wraddr <= owner_addr;
                                UB_wrdata <= owner_wrdata;
                            end else begin
                                UB_rdaddr <= owner_addr;
                                rd_pend   <= gnt;
                            end
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            if (beat_cnt + CNT_W'(1) == beat_target) begin
                                gnt   <= '0;
                                busy  <= 1'b0;
                                state <= RELEASE;
                            end
                        end else begin
                            UB_en   <= 1'b0;
                            UB_wren <= 1'b0;
                        end
                    end
                    RELEASE: begin
                        UB_en   <= 1'b0;
                        UB_wren <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ub_arbiter.sv
// tb/tb_ub_arbiter.sv - directed and randomized bursts against a transaction-level arbiter model
module tb_ub_arbiter;

    logic        CLK = 1'b0;
    logic        ASYNC_RST, SYNC_RST, EN;
    logic [2:0]  req, beat_valid, beat_wren;
    logic [23:0] req_len;
    logic [47:0] beat_addr;
    logic [23:0] beat_wrdata;
    logic [2:0]  gnt, rd_valid;
    logic [7:0]  rd_data, UB_wrdata, UB_rddata;
    logic        busy, UB_en, UB_wren;
    logic [15:0] UB_wraddr, UB_rdaddr;

    logic [7:0]  rom [256];

    logic [2:0]  exp_gnt;
    logic        exp_en, exp_wren;
    logic [15:0] exp_wraddr, exp_rdaddr;
    logic [7:0]  exp_wrdata;
    logic [2:0]  cur_rd_mask, rd_p_mask, rd_exp_mask;
    logic [15:0] cur_rd_addr, rd_p_addr, rd_exp_addr;
    int          exp_last;
    int          checks, errors;

    ub_arbiter dut (
        .CLK         (CLK),
        .ASYNC_RST   (ASYNC_RST),
        .SYNC_RST    (SYNC_RST),
        .EN          (EN),
        .req         (req),
        .req_len     (req_len),
        .beat_valid  (beat_valid),
        .beat_wren   (beat_wren),
        .beat_addr   (beat_addr),
        .beat_wrdata (beat_wrdata),
        .gnt         (gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .UB_en       (UB_en),
        .UB_wren     (UB_wren),
        .UB_wraddr   (UB_wraddr),
        .UB_wrdata   (UB_wrdata),
        .UB_rdaddr   (UB_rdaddr),
        .UB_rddata   (UB_rddata)
    );

    always #5 CLK = ~CLK;

    // Buffer memory model: read-only contents, data one cycle after the read address.
    always @(posedge CLK) UB_rddata <= rom[UB_rdaddr[7:0]];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [2:0] m, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (m[(last + k) % 3]) return (last + k) % 3;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_gnt = '0; exp_en = 1'b0; exp_wren = 1'b0;
        exp_wraddr = '0; exp_rdaddr = '0; exp_wrdata = '0;
        cur_rd_mask = '0; rd_p_mask = '0; rd_exp_mask = '0;
        cur_rd_addr = '0; rd_p_addr = '0; rd_exp_addr = '0;
        exp_last = 2;
    endtask

    task automatic check_all();
        chk("gnt",       32'(gnt),       32'(exp_gnt));
        chk("busy",      32'(busy),      32'(exp_gnt != 3'b0));
        chk("ub_en",     32'(UB_en),     32'(exp_en));
        chk("ub_wren",   32'(UB_wren),   32'(exp_wren));
        chk("ub_wraddr", 32'(UB_wraddr), 32'(exp_wraddr));
        chk("ub_wrdata", 32'(UB_wrdata), 32'(exp_wrdata));
        chk("ub_rdaddr", 32'(UB_rdaddr), 32'(exp_rdaddr));
        chk("rd_valid",  32'(rd_valid),  32'(rd_exp_mask));
        if (rd_exp_mask != 3'b0) chk("rd_data", 32'(rd_data), 32'(rom[rd_exp_addr[7:0]]));
    endtask

    task automatic step();
        @(negedge CLK);
        if (EN) begin
            rd_exp_mask = rd_p_mask; rd_exp_addr = rd_p_addr;
            rd_p_mask = cur_rd_mask; rd_p_addr = cur_rd_addr;
            cur_rd_mask = '0;
        end
        check_all();
    endtask

    // One arbitration round as seen by the requesters; starts and ends at a negedge in IDLE.
    task automatic burst(input logic [2:0] m, input int len, input bit wr, input bit gaps,
                         input int base_a, input int base_d, input int abort_at,
                         input int stall_at, input int rst_at, input bit rst_sync);
        int w, nb, lim, sent;
        bit present;
        logic [15:0] a;
        logic [7:0] d;
        w   = rr_pick(m, exp_last);
        nb  = (len == 0) ? 1 : len;
        lim = (abort_at >= 0 && abort_at < nb) ? abort_at : nb;
        req = m; req_len = {3{8'(len)}}; beat_valid = '0;
        exp_gnt = 3'(1 << w); exp_en = 1'b0; exp_wren = 1'b0; exp_last = w;
        step();
        sent = 0;
        for (int g = 0; g < 64 && sent < lim; g++) begin
            if (sent == rst_at) begin
                req = '0; beat_valid = '0;
                clear_model();
                if (!rst_sync) begin
                    ASYNC_RST = 1'b0; #1; check_all(); #1; ASYNC_RST = 1'b1;
                end else begin
                    SYNC_RST = 1'b1; step(); SYNC_RST = 1'b0;
                end
                step();
                return;
            end
            present = !gaps || g >= 32 || ($urandom_range(0, 2) != 0);
            a = (base_a >= 0) ? 16'(base_a + sent) : 16'($urandom);
            d = (base_d >= 0) ? 8'(base_d + sent) : 8'($urandom);
            for (int j = 0; j < 3; j++) begin
                beat_valid[j] = 1'($urandom); beat_wren[j] = 1'($urandom);
                beat_addr[j*16 +: 16] = 16'($urandom); beat_wrdata[j*8 +: 8] = 8'($urandom);
            end
            beat_valid[w] = present; beat_wren[w] = wr;
            beat_addr[w*16 +: 16] = a; beat_wrdata[w*8 +: 8] = d;
            if (stall_at == sent && present) begin
                EN = 1'b0;
                repeat (5) step();
                EN = 1'b1;
                stall_at = -1;
            end
            if (present) begin
                sent++;
                exp_en = 1'b1; exp_wren = wr;
                if (wr) begin
                    exp_wraddr = a; exp_wrdata = d;
                end else begin
                    exp_rdaddr = a; cur_rd_mask = 3'(1 << w); cur_rd_addr = a;
                end
                if (sent == nb) exp_gnt = '0;
            end else begin
                exp_en = 1'b0; exp_wren = 1'b0;
            end
            step();
        end
        if (lim < nb) begin
            req = m & ~3'(1 << w); beat_valid[w] = 1'b1;
            exp_gnt = '0; exp_en = 1'b0; exp_wren = 1'b0;
            step();
        end
        req = '0; beat_valid = '0;
        exp_en = 1'b0; exp_wren = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h40] = 8'h55;
        rom[8'h41] = 8'h66;
        checks = 0; errors = 0;
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b1;
        req = '0; req_len = '0; beat_valid = '0; beat_wren = '0;
        beat_addr = '0; beat_wrdata = '0;
        clear_model();
        repeat (2) @(negedge CLK);
        check_all();
        ASYNC_RST = 1'b1;
        step();

        repeat (4) burst(3'b111, 0, 1'b1, 1'b0, -1, -1, -1, -1, -1, 1'b0);
        burst(3'b001, 4, 1'b1, 1'b0, 'h10, 'hA0, -1, -1, -1, 1'b0);
        burst(3'b100, 2, 1'b0, 1'b0, 'h40, -1, -1, -1, -1, 1'b0);
        burst(3'b110, 8, 1'b1, 1'b0, -1, -1, 3, -1, -1, 1'b0);
        burst(3'b100, 1, 1'b1, 1'b0, -1, -1, -1, -1, -1, 1'b0);
        burst(3'b001, 6, 1'b1, 1'b1, -1, -1, -1, 2, -1, 1'b0);
        burst(3'b010, 5, 1'b0, 1'b0, -1, -1, -1, -1, 2, 1'b0);
        burst(3'b111, 0, 1'b1, 1'b0, -1, -1, -1, -1, -1, 1'b0);
        burst(3'b100, 4, 1'b1, 1'b0, -1, -1, -1, -1, 1, 1'b1);
        burst(3'b011, 3, 1'b0, 1'b1, -1, -1, -1, 1, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            burst(3'($urandom_range(1, 7)), $urandom_range(0, 5), 1'($urandom), 1'b1, -1, -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
